// File: rtl/gte_sel_mul_pipe.sv
// gte_sel_mul_pipe: LANES-wide GTE operand select + signed multiply behind a 2-stage valid/ready pipe.
// Optional per-lane product accumulator is built when GTE_SELMUL_ACC_EN is defined.
module gte_sel_mul_pipe #(
  parameter int LANES = 3,
  parameter int OPW   = 16,
  parameter int RW    = 2*OPW+5
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_isMVMVA,
  input  logic [1:0]               i_mx,
  input  logic [1:0]               i_vec,
  input  logic [1:0]               i_ctlMat,
  input  logic [1:0]               i_ctlVec,
  input  logic                     i_wide,
  input  logic [2:0]               i_selLeft,
  input  logic [2:0]               i_selRight,
  input  logic [4*LANES*3*OPW-1:0] i_mat,
  input  logic [3*LANES*OPW-1:0]   i_vecs,
  input  logic [LANES*OPW-1:0]     i_irn,
  input  logic [LANES*OPW-1:0]     i_tmp,
  input  logic [OPW-1:0]           i_ir0,
  input  logic [LANES*8-1:0]       i_color,
`ifdef GTE_SELMUL_ACC_EN
  input  logic                     i_acc,
  input  logic                     i_accClr,
  output logic [LANES*(RW+4)-1:0]  o_acc,
`endif
  output logic                     o_valid,
  input  logic                     i_outReady,
  output logic [LANES*RW-1:0]      o_prod
);

  localparam int LW  = OPW + 1;
  localparam int RRW = OPW + 4;
  localparam int AW  = RW + 4;

  logic       r_s1_valid, r_s2_valid;
  logic       w_s2_free, w_accept, w_s1_load, w_s2_load;
  logic [1:0] w_m, w_v;

  assign w_m = i_isMVMVA ? i_mx  : i_ctlMat;
  assign w_v = i_isMVMVA ? i_vec : i_ctlVec;

  // S2 frees up when empty or draining; S1 may then move forward in the same cycle.
  assign w_s2_free = !r_s2_valid || i_outReady;
  assign o_ready   = !r_s1_valid || w_s2_free;
  assign w_accept  = i_valid && o_ready;
  assign w_s1_load = w_accept && !i_flush;
  assign w_s2_load = r_s1_valid && w_s2_free && !i_flush;
  assign o_valid   = r_s2_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_accept)       r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;
      if (w_s2_load)       r_s2_valid <= 1'b1;
      else if (i_outReady) r_s2_valid <= 1'b0;
    end
  end

`ifdef GTE_SELMUL_ACC_EN
  logic r_s1_acc, r_s1_accclr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_acc    <= 1'b0;
      r_s1_accclr <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_acc    <= i_acc;
      r_s1_accclr <= i_accClr;
    end
  end
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [OPW-1:0] w_irn, w_tmp, w_matc, w_vcomp;
    logic        [11:0]    w_col16;
    logic        [1:0]     w_col, w_vi;
    logic signed [LW-1:0]  w_left, r_left;
    logic signed [RRW-1:0] w_rsel, w_right, r_right;
    logic signed [RW-1:0]  w_prod, r_prod;

    assign w_irn   = i_irn[l*OPW +: OPW];
    assign w_tmp   = i_tmp[l*OPW +: OPW];
    assign w_col16 = {i_color[l*8 +: 8], 4'b0000};
    assign w_col   = (i_selLeft < 3'd3) ? i_selLeft[1:0] : 2'd0;
    assign w_vi    = (w_v == 2'd3) ? 2'd0 : w_v;
    assign w_matc  = i_mat[((int'(w_m)*LANES + l)*3 + int'(w_col))*OPW +: OPW];
    // Vector slot 3 aliases IRn or tmp depending on the control vector field.
    assign w_vcomp = (w_v != 2'd3) ? i_vecs[(int'(w_vi)*LANES + l)*OPW +: OPW]
                   : (i_ctlVec == 2'd0) ? w_irn : w_tmp;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
      w_left = '0;
      case (i_selLeft)
        3'd0, 3'd1, 3'd2: w_left = LW'(w_matc);
        3'd3:             w_left = LW'(w_col16);
        3'd4:             w_left = LW'(w_irn);
        3'd5:             w_left = LW'(4096);
        3'd6:             w_left = LW'(-4096);
        default:          w_left = '0;
      endcase
    end

    always_comb begin
      w_rsel = '0;
      case (i_selRight)
        3'd0:    w_rsel = RRW'(w_vcomp);
        3'd1:    w_rsel = RRW'(w_tmp);
        3'd2:    w_rsel = RRW'(w_irn);
        3'd3:    w_rsel = RRW'($signed(i_ir0));
        3'd4:    w_rsel = RRW'(w_col16);
        default: w_rsel = '0;
      endcase
    end

    assign w_right = i_wide ? (w_rsel <<< 2) : w_rsel;
    assign w_prod  = RW'(r_left) * RW'(r_right);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_left  <= '0;
        r_right <= '0;
        r_prod  <= '0;
      end else begin
        if (w_s1_load) begin
          r_left  <= w_left;
          r_right <= w_right;
        end
        if (w_s2_load) r_prod <= w_prod;
      end
    end

    assign o_prod[l*RW +: RW] = r_prod;

`ifdef GTE_SELMUL_ACC_EN
    logic signed [AW-1:0] r_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_acc <= '0;
      end else if (w_s2_load) begin
        if (r_s1_acc)         r_acc <= (r_s1_accclr ? AW'(0) : r_acc) + AW'(w_prod);
        else if (r_s1_accclr) r_acc <= '0;
      end
    end

    assign o_acc[l*AW +: AW] = r_acc;
`endif
  end

endmodule

// File: tb/tb_gte_sel_mul_pipe.sv
// Self-checking bench for gte_sel_mul_pipe: directed cases plus randomized traffic against a FIFO/latency model.
// Accumulator checks are compiled in when GTE_SELMUL_ACC_EN is defined.
module tb_gte_sel_mul_pipe;
  localparam int LANES = 3;
  localparam int OPW   = 16;
  localparam int RW    = 2*OPW+5;
  localparam int PW    = LANES*RW;
  localparam int AW    = RW+4;

  logic                     clk = 1'b0;
  logic                     i_rst, i_flush, i_valid, o_ready;
  logic                     i_isMVMVA, i_wide, o_valid, i_outReady;
  logic [1:0]               i_mx, i_vec, i_ctlMat, i_ctlVec;
  logic [2:0]               i_selLeft, i_selRight;
  logic [4*LANES*3*OPW-1:0] i_mat;
  logic [3*LANES*OPW-1:0]   i_vecs;
  logic [LANES*OPW-1:0]     i_irn, i_tmp;
  logic [OPW-1:0]           i_ir0;
  logic [LANES*8-1:0]       i_color;
  logic [PW-1:0]            o_prod;
`ifdef GTE_SELMUL_ACC_EN
  logic                     i_acc, i_accClr;
  logic [LANES*AW-1:0]      o_acc;
`endif

  always #5 clk = ~clk;

  gte_sel_mul_pipe dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_isMVMVA(i_isMVMVA), .i_mx(i_mx), .i_vec(i_vec), .i_ctlMat(i_ctlMat), .i_ctlVec(i_ctlVec),
    .i_wide(i_wide), .i_selLeft(i_selLeft), .i_selRight(i_selRight), .i_mat(i_mat), .i_vecs(i_vecs),
    .i_irn(i_irn), .i_tmp(i_tmp), .i_ir0(i_ir0), .i_color(i_color),
`ifdef GTE_SELMUL_ACC_EN
    .i_acc(i_acc), .i_accClr(i_accClr), .o_acc(o_acc),
`endif
    .o_valid(o_valid), .i_outReady(i_outReady), .o_prod(o_prod)
  );

  typedef struct {
    int            t;
    logic [PW-1:0] prod;
  } item_t;

  item_t q[$];
  int    n      = 0;
  int    errors = 0;
  int    checks = 0;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(logic [OPW-1:0] x);
    return longint'($signed(x));
  endfunction

  // Pack three per-lane values into LANES slices of width w.
  function automatic logic [127:0] pack(longint a, longint b, longint c, int w);
    logic [127:0] r;
    logic [63:0]  v[3];
    r = '0;
    v[0] = a; v[1] = b; v[2] = c;
    for (int l = 0; l < LANES; l++)
      for (int b2 = 0; b2 < w; b2++) r[l*w + b2] = v[l][b2];
    return r;
  endfunction

  // Arithmetic reference: product per lane from the operand-selection rules.
  function automatic logic [PW-1:0] model();
    logic [PW-1:0] r;
    int            m, v;
    longint        lft, rgt, p, irn, tmp, col;
    r = '0;
    m = i_isMVMVA ? int'(i_mx)  : int'(i_ctlMat);
    v = i_isMVMVA ? int'(i_vec) : int'(i_ctlVec);
    for (int l = 0; l < LANES; l++) begin
      irn = sx(i_irn[l*OPW +: OPW]);
      tmp = sx(i_tmp[l*OPW +: OPW]);
      col = longint'(i_color[l*8 +: 8]) * 16;
      case (int'(i_selLeft))
        0, 1, 2: lft = sx(i_mat[((m*LANES + l)*3 + int'(i_selLeft))*OPW +: OPW]);
        3:       lft = col;
        4:       lft = irn;
        5:       lft = 4096;
        6:       lft = -4096;
        default: lft = 0;
      endcase
      case (int'(i_selRight))
        0:       rgt = (v < 3) ? sx(i_vecs[(v*LANES + l)*OPW +: OPW]) : ((i_ctlVec == 2'd0) ? irn : tmp);
        1:       rgt = tmp;
        2:       rgt = irn;
        3:       rgt = sx(i_ir0);
        4:       rgt = col;
        default: rgt = 0;
      endcase
      if (i_wide) rgt = rgt * 4;
      p = lft * rgt;
      r[l*RW +: RW] = p[RW-1:0];
    end
    return r;
  endfunction

  // One clock: compare outputs against the model at the falling edge, then advance.
  task automatic cycle();
    logic ev, er;
    @(negedge clk);
    ev = (q.size() > 0) && (n - q[0].t >= 2);
    er = (q.size() < 2) || i_outReady;
    check("o_valid", 128'(o_valid), 128'(ev));
    check("o_ready", 128'(o_ready), 128'(er));
    if (ev) check("o_prod", 128'(o_prod), 128'(q[0].prod));
    if (i_flush) q.delete();
    else begin
      if (ev && i_outReady) void'(q.pop_front());
      if (i_valid && er) q.push_back('{t: n, prod: model()});
    end
    n++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ops();
    i_isMVMVA = 1'b1; i_mx = '0; i_vec = '0; i_ctlMat = '0; i_ctlVec = '0;
    i_wide = 1'b0; i_selLeft = '0; i_selRight = '0; i_mat = '0; i_vecs = '0;
    i_irn = '0; i_tmp = '0; i_ir0 = '0; i_color = '0;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < 4*LANES*3; k++) i_mat[k*OPW +: OPW] = OPW'($urandom);
    for (int k = 0; k < 3*LANES; k++)   i_vecs[k*OPW +: OPW] = OPW'($urandom);
    for (int k = 0; k < LANES; k++) begin
      i_irn[k*OPW +: OPW] = OPW'($urandom);
      i_tmp[k*OPW +: OPW] = OPW'($urandom);
      i_color[k*8 +: 8]   = 8'($urandom);
    end
    i_ir0      = OPW'($urandom);
    i_isMVMVA  = 1'($urandom);
    i_wide     = 1'($urandom);
    i_mx       = 2'($urandom);
    i_vec      = 2'($urandom);
    i_ctlMat   = 2'($urandom);
    i_ctlVec   = 2'($urandom);
    i_selLeft  = 3'($urandom);
    i_selRight = 3'($urandom);
  endtask

  // Send one item into an empty pipe and check the product at t+2 against a constant.
  task automatic single(string tag, logic [127:0] exp);
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    cycle();
    check({tag, "_valid"}, 128'(o_valid), 128'(1));
    check(tag, 128'(o_prod), exp);
    cycle();
  endtask

  task automatic async_reset(string tag);
    #2 i_rst = 1'b1;
    #1;
    check({tag, "_valid"}, 128'(o_valid), 128'(0));
    check({tag, "_prod"}, 128'(o_prod), 128'(0));
    check({tag, "_ready"}, 128'(o_ready), 128'(1));
`ifdef GTE_SELMUL_ACC_EN
    check({tag, "_acc"}, 128'(o_acc), 128'(0));
`endif
    i_valid = 1'b0;
    i_flush = 1'b0;
    q.delete();
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_outReady = 1'b1;
`ifdef GTE_SELMUL_ACC_EN
    i_acc = 1'b0; i_accClr = 1'b0;
`endif
    clear_ops();
    @(posedge clk); #1;
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_prod", 128'(o_prod), 128'(0));
    check("rst_ready", 128'(o_ready), 128'(1));
    i_rst = 1'b0;
    @(posedge clk); #1;

    // MVMVA: MAT0 column 0 = 0x1000 on each row, V1 = (3,-2,7).
    clear_ops();
    i_mx = 2'd0; i_vec = 2'd1;
    for (int l = 0; l < LANES; l++) i_mat[(0*LANES + l)*3*OPW +: OPW] = 16'h1000;
    i_vecs[(1*LANES + 0)*OPW +: OPW] = 16'd3;
    i_vecs[(1*LANES + 1)*OPW +: OPW] = -16'sd2;
    i_vecs[(1*LANES + 2)*OPW +: OPW] = 16'd7;
    single("mvmva_v1", pack(12288, -8192, 28672, RW));

    // -4096 x (0xFF0 << 2) must not truncate.
    clear_ops();
    i_selLeft = 3'd6; i_selRight = 3'd4; i_color = {LANES{8'hFF}}; i_wide = 1'b1;
    single("wide_color", pack(-66846720, -66846720, -66846720, RW));

    // Vector slot 3 quirk and garbage matrix.
    clear_ops();
    for (int l = 0; l < LANES; l++) begin
      i_irn[l*OPW +: OPW] = OPW'(l + 1);
      i_tmp[l*OPW +: OPW] = OPW'(l + 5);
      i_mat[((3*LANES + l)*3 + 1)*OPW +: OPW] = OPW'(100 + l);
    end
    i_vec = 2'd3; i_selLeft = 3'd5; i_selRight = 3'd0;
    i_ctlVec = 2'd0;
    single("v3_irn", pack(4096, 8192, 12288, RW));
    i_ctlVec = 2'd1;
    single("v3_tmp", pack(20480, 24576, 28672, RW));
    i_isMVMVA = 1'b0; i_ctlVec = 2'd3;
    single("ctl_v3_tmp", pack(20480, 24576, 28672, RW));
    i_isMVMVA = 1'b1; i_mx = 2'd3; i_selLeft = 3'd1; i_selRight = 3'd3; i_ir0 = 16'd2;
    single("garbage_mat", pack(200, 202, 204, RW));

    // Five-item stream with downstream stalled for three cycles.
    for (int k = 0; k < 12; k++) begin
      i_outReady = !(k >= 3 && k <= 5);
      i_valid    = (k < 5);
      rand_ops();
      cycle();
    end
    i_outReady = 1'b1;
    i_valid    = 1'b0;
    repeat (3) cycle();

    // Flush with two in flight and a new item offered on the same cycle.
    rand_ops(); i_valid = 1'b1;
    cycle();
    rand_ops();
    cycle();
    rand_ops(); i_flush = 1'b1;
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    check("flush_valid", 128'(o_valid), 128'(0));
    check("flush_ready", 128'(o_ready), 128'(1));
    repeat (3) cycle();

    // Randomized traffic with back-pressure and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      i_valid    = ($urandom_range(9) < 7);
      i_outReady = ($urandom_range(9) < 7);
      i_flush    = ($urandom_range(31) == 0);
      cycle();
    end
    i_flush = 1'b0; i_valid = 1'b0; i_outReady = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset in the middle of a stream.
    for (int k = 0; k < 3; k++) begin
      rand_ops(); i_valid = 1'b1;
      cycle();
    end
    async_reset("mid_rst");
    repeat (3) cycle();

`ifdef GTE_SELMUL_ACC_EN
    clear_ops();
    i_selLeft = 3'd4; i_selRight = 3'd3; i_ir0 = 16'd1;
    i_acc = 1'b1; i_accClr = 1'b1;
    i_irn = {LANES{16'd10}};
    single("acc_p0", pack(10, 10, 10, RW));
    check("acc_0", 128'(o_acc), pack(10, 10, 10, AW));
    i_accClr = 1'b0;
    i_irn = {LANES{16'd20}};
    single("acc_p1", pack(20, 20, 20, RW));
    check("acc_1", 128'(o_acc), pack(30, 30, 30, AW));
    i_irn = {LANES{-16'sd5}};
    single("acc_p2", pack(-5, -5, -5, RW));
    check("acc_2", 128'(o_acc), pack(25, 25, 25, AW));
    i_acc = 1'b0; i_accClr = 1'b1;
    i_irn = {LANES{16'd7}};
    single("acc_p3", pack(7, 7, 7, RW));
    check("acc_clr", 128'(o_acc), pack(0, 0, 0, AW));
    i_acc = 1'b1; i_accClr = 1'b0;
    i_irn = {LANES{16'd3}};
    single("acc_p4", pack(3, 3, 3, RW));
    check("acc_4", 128'(o_acc), pack(3, 3, 3, AW));
    i_valid = 1'b1;
    cycle();
    async_reset("acc_rst");
    i_acc = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
